// File: rtl/rpm_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rpm_pkg
//  Description : Shared types, constants and the per-gear ceiling function
//                used by the RPM gear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package rpm_pkg;

  // Gear position width (up to 8 gears including neutral)
  localparam int GEAR_W = 3;

  // Controller operating state
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_LIMIT = 1'b1
  } rpm_state_t;

  // Neutral is unrestricted. Gear g>=1 allows base + step*(g-1), clipped to
  // lvl_max. Integer arithmetic is wide enough that the sum never wraps
  // before it is saturated.
  function automatic int gear_ceiling(input logic [GEAR_W-1:0] gear,
                                      input int base,
                                      input int step,
                                      input int lvl_max);
    int raw;
    if (gear == '0) begin
      return lvl_max;
    end
    raw = base + step * (int'(gear) - 1);
    return (raw > lvl_max) ? lvl_max : raw;
  endfunction

endpackage : rpm_pkg
`default_nettype wire

// File: rtl/rpm_gear_engine_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_timer
//  Description : Restartable down-counter. While enabled it flags expire for
//                one cycle every TICKS enabled cycles after a restart, then
//                starts the next period by itself.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_timer #(
  parameter int TICKS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TICKS + 1);

  // Zero means "fresh period"; the first enabled cycle loads TICKS-1.
  logic [CNT_W-1:0] count;

  assign expire = enable && !restart &&
                  ((count == CNT_W'(1)) || (TICKS == 1));

  // Count enabled cycles; restart has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      if (expire) begin
        count <= '0;
      end else if (count == '0) begin
        count <= CNT_W'(TICKS - 1);
      end else begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule : tick_timer
`default_nettype wire

// File: rtl/rpm_gear_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rpm_gear_engine
//  Description : Speed-level controller with per-gear ceilings, accel repeat,
//                coast decay, rev limiter and optional automatic shifting.
//  Revision    : 1.0 - initial release
// ============================================================================
module rpm_gear_engine
  import rpm_pkg::*;
#(
  parameter int LEVEL_W      = 4,
  parameter int NUM_GEARS    = 6,
  parameter int MAX_BASE     = 6,
  parameter int MAX_STEP     = 2,
  parameter int REPEAT_TICKS = 200,
  parameter int DECAY_TICKS  = 500,
  parameter int LIMIT_CYCLES = 300,
  parameter int LIMIT_DROP   = 2,
  parameter int DOWN_THR     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accel_pulse,
  input  logic               decel_pulse,
  input  logic               accel_level,
  input  logic [GEAR_W-1:0]  gear_req,
  input  logic               auto_mode,
  output logic [LEVEL_W-1:0] speed_level,
  output logic [LEVEL_W-1:0] max_level,
  output logic [GEAR_W-1:0]  gear_cur,
  output logic               limiter_active,
  output logic               shift_evt
);

  localparam int                LVL_MAX  = (1 << LEVEL_W) - 1;
  localparam logic [GEAR_W-1:0] TOP_GEAR = GEAR_W'(NUM_GEARS - 1);

  rpm_state_t         state, state_n;
  logic [LEVEL_W-1:0] level_n;
  logic [GEAR_W-1:0]  gear_n;
  logic               shift_n;
  logic               upshift;
  logic [GEAR_W-1:0]  manual_tgt;
  logic [LEVEL_W-1:0] ceil_n;

  logic rep_exp, dec_exp, lim_exp;
  logic accel_evt;
  logic dec_en, lim_en;

  assign max_level      = LEVEL_W'(gear_ceiling(gear_cur, MAX_BASE, MAX_STEP, LVL_MAX));
  assign limiter_active = (state == ST_LIMIT);
  assign accel_evt      = accel_pulse | rep_exp;
  assign manual_tgt     = (gear_req > TOP_GEAR) ? TOP_GEAR : gear_req;

  // Coast decay only runs in RUN while the driver is completely idle.
  assign dec_en = (state == ST_RUN) && !accel_level && !accel_evt && !decel_pulse;
  assign lim_en = (state == ST_LIMIT);

  tick_timer #(.TICKS(REPEAT_TICKS)) u_repeat (
    .clk     (clk),
    .rst     (rst),
    .restart (accel_pulse | ~accel_level),
    .enable  (accel_level),
    .expire  (rep_exp)
  );

  tick_timer #(.TICKS(DECAY_TICKS)) u_decay (
    .clk     (clk),
    .rst     (rst),
    .restart (~dec_en),
    .enable  (dec_en),
    .expire  (dec_exp)
  );

  tick_timer #(.TICKS(LIMIT_CYCLES)) u_limit (
    .clk     (clk),
    .rst     (rst),
    .restart (~lim_en),
    .enable  (lim_en),
    .expire  (lim_exp)
  );

  // Register state, level, gear and the shift pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      speed_level <= '0;
      gear_cur    <= '0;
      shift_evt   <= 1'b0;
    end else begin
      state       <= state_n;
      speed_level <= level_n;
      gear_cur    <= gear_n;
      shift_evt   <= shift_n;
    end
  end

  // Level events first, then at most one gear change which may override them.
  always_comb begin
    state_n = state;
    level_n = speed_level;
    gear_n  = gear_cur;
    shift_n = 1'b0;
    upshift = 1'b0;
    ceil_n  = max_level;

    case (state)
      ST_RUN: begin
        if (accel_evt && decel_pulse) begin
          level_n = speed_level;
        end else if (accel_evt) begin
          if (speed_level < max_level) begin
            level_n = speed_level + LEVEL_W'(1);
          end else if (auto_mode && (gear_cur != '0) && (gear_cur < TOP_GEAR)) begin
            upshift = 1'b1;
          end else begin
            state_n = ST_LIMIT;
          end
        end else if (decel_pulse || dec_exp) begin
          if (speed_level != '0) begin
            level_n = speed_level - LEVEL_W'(1);
          end
        end
      end
      ST_LIMIT: begin
        // Accel and repeat are ignored while the limiter cuts.
        if (decel_pulse) begin
          if (speed_level != '0) begin
            level_n = speed_level - LEVEL_W'(1);
          end
          state_n = ST_RUN;
        end else if (lim_exp) begin
          level_n = (speed_level > LEVEL_W'(LIMIT_DROP)) ?
                    speed_level - LEVEL_W'(LIMIT_DROP) : '0;
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_RUN;
      end
    endcase

    if (!auto_mode) begin
      gear_n = manual_tgt;
    end else if (gear_cur == '0) begin
      gear_n = GEAR_W'(1);
    end else if (upshift) begin
      gear_n = gear_cur + GEAR_W'(1);
    end else if ((speed_level < LEVEL_W'(DOWN_THR)) && (gear_cur > GEAR_W'(1))) begin
      gear_n = gear_cur - GEAR_W'(1);
    end

    if (gear_n != gear_cur) begin
      shift_n = 1'b1;
      ceil_n  = LEVEL_W'(gear_ceiling(gear_n, MAX_BASE, MAX_STEP, LVL_MAX));
      if (upshift) begin
        level_n = speed_level >> 1;
      end else begin
        // Any other gear change aborts LIMIT and respects the new ceiling.
        state_n = ST_RUN;
        if (level_n > ceil_n) begin
          level_n = ceil_n;
        end
      end
    end
  end

endmodule : rpm_gear_engine
`default_nettype wire
